// File: rtl/dense_seq_if.sv
// rtl/dense_seq_if.sv - command and buffer/PE-array control bundle for dense_seq
//
// Purpose: groups the layer command (start + shape + base addresses) and the
// sequencer outputs that steer the buffers and the PE array.
// Ports (signals):
//   start, ping, num_inputs, num_outputs, w_base, x_base, y_base : command
//   aybz_azby          : dense routing mode {1'b1, ping}
//   src_r_en/src_r_addr: source-buffer read, common address to all banks
//   x_r_addr           : bank-32 input-vector word address (x_base + k)
//   dst_w_en/dst_w_addr: destination-buffer write
//   mac_enable         : per-lane MAC enable
//   dense_enable, dense_valid, busy, done : PE-array mode and layer status
// Modports: master drives the command, slave is the sequencer.
`ifndef N_PE
`define N_PE 32
`endif

interface dense_seq_if #(
  parameter int N_PE   = `N_PE,
  parameter int ADDR_W = 10
);
  logic              start;
  logic              ping;
  logic [15:0]       num_inputs;
  logic [15:0]       num_outputs;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] y_base;

  logic [1:0]        aybz_azby;
  logic              src_r_en;
  logic [ADDR_W-1:0] src_r_addr;
  logic [ADDR_W-1:0] x_r_addr;
  logic              dst_w_en;
  logic [ADDR_W-1:0] dst_w_addr;
  logic [N_PE-1:0]   mac_enable;
  logic              dense_enable;
  logic              dense_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, ping, num_inputs, num_outputs, w_base, x_base, y_base,
    input  aybz_azby, src_r_en, src_r_addr, x_r_addr, dst_w_en, dst_w_addr,
    input  mac_enable, dense_enable, dense_valid, busy, done
  );

  modport slave (
    input  start, ping, num_inputs, num_outputs, w_base, x_base, y_base,
    output aybz_azby, src_r_en, src_r_addr, x_r_addr, dst_w_en, dst_w_addr,
    output mac_enable, dense_enable, dense_valid, busy, done
  );
endinterface

// File: rtl/dense_seq.sv
// rtl/dense_seq.sv - dense-layer sequencer: weight reads, MAC enables, drain, result writes
//
// Purpose: for each group of N_PE output neurons, streams K weight/input reads,
// enables the active PE lanes one cycle behind each read, waits for the
// accumulators, pulses dense_valid, then writes the group's results.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dense_seq_if slave (command in, buffer/PE-array controls out)
`ifndef N_PE
`define N_PE 32
`endif

module dense_seq #(
  parameter int N_PE     = `N_PE,
  parameter int ADDR_W   = 10,
  parameter int PIPE_LAT = 3
) (
  input logic        clk,
  input logic        rst,
  dense_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, NEXT, FIN} state_t;

  state_t            state;
  logic              ping_q;
  logic [15:0]       k_in_q;
  logic [15:0]       m_q;
  logic [ADDR_W-1:0] x_base_q;
  logic [15:0]       k_q;
  logic [15:0]       g_q;
  logic [15:0]       j_q;
  logic [7:0]        drain_q;

  // Full-width address pointers; outputs take the low ADDR_W bits so all
  // address arithmetic wraps modulo 2^ADDR_W.
  logic [31:0]       rd_ptr;
  logic [31:0]       wr_ptr;
  logic [31:0]       x_ptr;

  logic              src_r_en_q;
  logic [ADDR_W-1:0] src_r_addr_q;
  logic [ADDR_W-1:0] x_r_addr_q;
  logic              dst_w_en_q;
  logic [ADDR_W-1:0] dst_w_addr_q;
  logic [N_PE-1:0]   mac_q;
  logic              dense_en_q;
  logic              dense_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [31:0]       rem;
  logic [31:0]       lane_cnt;
  logic [N_PE-1:0]   lane_mask;
  logic [31:0]       rd_nxt;
  logic [31:0]       wr_nxt;
  logic [31:0]       x_nxt;
  logic [15:0]       k_last;

  // Outputs still owed to this group and the lanes they occupy.
  always_comb begin
    rem       = {16'd0, m_q} - ({16'd0, g_q} * 32'(N_PE));
    lane_cnt  = (rem > 32'(N_PE)) ? 32'(N_PE) : rem;
    lane_mask = '0;
    for (int i = 0; i < N_PE; i++) begin
      lane_mask[i] = (32'(i) < lane_cnt);
    end
    rd_nxt = rd_ptr + 32'd1;
    wr_nxt = wr_ptr + 32'd1;
    x_nxt  = x_ptr + 32'd1;
    k_last = k_in_q - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ping_q        <= 1'b1;
      k_in_q        <= '0;
      m_q           <= '0;
      x_base_q      <= '0;
      k_q           <= '0;
      g_q           <= '0;
      j_q           <= '0;
      drain_q       <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      x_ptr         <= '0;
      src_r_en_q    <= 1'b0;
      src_r_addr_q  <= '0;
      x_r_addr_q    <= '0;
      dst_w_en_q    <= 1'b0;
      dst_w_addr_q  <= '0;
      mac_q         <= '0;
      dense_en_q    <= 1'b0;
      dense_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      dense_valid_q <= 1'b0;
      // Buffer read latency is one cycle, so lanes fire one cycle after each read.
      mac_q         <= src_r_en_q ? lane_mask : '0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            ping_q     <= bus.ping;
            k_in_q     <= bus.num_inputs;
            m_q        <= bus.num_outputs;
            x_base_q   <= bus.x_base;
            k_q        <= '0;
            g_q        <= '0;
            j_q        <= '0;
            rd_ptr     <= 32'(bus.w_base);
            wr_ptr     <= 32'(bus.y_base);
            x_ptr      <= 32'(bus.x_base);
            busy_q     <= 1'b1;
            dense_en_q <= 1'b1;
            if (bus.num_inputs == 16'd0 || bus.num_outputs == 16'd0) begin
              state <= FIN;
            end else begin
              state        <= READ;
              src_r_en_q   <= 1'b1;
              src_r_addr_q <= bus.w_base;
              x_r_addr_q   <= bus.x_base;
            end
          end
        end

        READ: begin
          rd_ptr <= rd_nxt;
          x_ptr  <= x_nxt;
          if (k_q == k_last) begin
            src_r_en_q    <= 1'b0;
            drain_q       <= '0;
            dense_valid_q <= (PIPE_LAT == 0);
            state         <= DRAIN;
          end else begin
            k_q          <= k_q + 16'd1;
            src_r_addr_q <= rd_nxt[ADDR_W-1:0];
            x_r_addr_q   <= x_nxt[ADDR_W-1:0];
          end
        end

        // drain_q indexes the drain cycle; dense_valid lands on the last one.
        DRAIN: begin
          if (drain_q == 8'(PIPE_LAT)) begin
            j_q          <= '0;
            dst_w_en_q   <= 1'b1;
            dst_w_addr_q <= wr_ptr[ADDR_W-1:0];
            state        <= WRITE;
          end else begin
            drain_q       <= drain_q + 8'd1;
            dense_valid_q <= ((drain_q + 8'd1) == 8'(PIPE_LAT));
          end
        end

        WRITE: begin
          wr_ptr <= wr_nxt;
          if ({16'd0, j_q} == lane_cnt - 32'd1) begin
            dst_w_en_q <= 1'b0;
            state      <= NEXT;
          end else begin
            j_q          <= j_q + 16'd1;
            dst_w_addr_q <= wr_nxt[ADDR_W-1:0];
          end
        end

        // rem still reflects the finished group: it was the last one when it fit in N_PE lanes.
        NEXT: begin
          g_q <= g_q + 16'd1;
          if (rem <= 32'(N_PE)) begin
            state <= FIN;
          end else begin
            k_q          <= '0;
            src_r_en_q   <= 1'b1;
            src_r_addr_q <= rd_ptr[ADDR_W-1:0];
            x_ptr        <= 32'(x_base_q);
            x_r_addr_q   <= x_base_q;
            state        <= READ;
          end
        end

        FIN: begin
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          dense_en_q <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.aybz_azby    = {1'b1, ping_q};
  assign bus.src_r_en     = src_r_en_q;
  assign bus.src_r_addr   = src_r_addr_q;
  assign bus.x_r_addr     = x_r_addr_q;
  assign bus.dst_w_en     = dst_w_en_q;
  assign bus.dst_w_addr   = dst_w_addr_q;
  assign bus.mac_enable   = mac_q;
  assign bus.dense_enable = dense_en_q;
  assign bus.dense_valid  = dense_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_dense_seq.sv
// tb/tb_dense_seq.sv - scoreboard testbench for dense_seq
`timescale 1ns/1ps

module tb_dense_seq;
  localparam int N_PE     = 32;
  localparam int ADDR_W   = 10;
  localparam int PIPE_LAT = 3;
  localparam int AMOD     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dense_seq_if #(.N_PE(N_PE), .ADDR_W(ADDR_W)) bus();

  dense_seq #(.N_PE(N_PE), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int q_rd[$];
  int q_x[$];
  int q_mac[$];
  int q_wr[$];
  int rd_cyc[$];
  int dv_exp = 0;
  int done_exp = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_rd = 0;
  bit mon_off = 1'b0;
  logic [1:0] exp_aybz = 2'b11;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] mask_of(input int lanes);
    logic [63:0] m;
    m = (64'd1 << lanes) - 64'd1;
    return m[31:0];
  endfunction

  // Reference model: the layer is a list of groups; each group reads K
  // consecutive weights, enables its lanes K times, captures once, writes its results.
  task automatic push_model(input int k, input int m, input int wb, input int xb, input int yb);
    if (k == 0 || m == 0) begin
      done_exp++;
      return;
    end
    for (int g = 0; g * N_PE < m; g++) begin
      int lanes;
      lanes = (m - g * N_PE > N_PE) ? N_PE : (m - g * N_PE);
      for (int kk = 0; kk < k; kk++) begin
        q_rd.push_back((wb + g * k + kk) % AMOD);
        q_x.push_back((xb + kk) % AMOD);
        q_mac.push_back(lanes);
      end
      dv_exp++;
      for (int j = 0; j < lanes; j++) q_wr.push_back((yb + g * N_PE + j) % AMOD);
    end
    done_exp++;
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_off && !rst) begin
        chk("rd_wr_overlap", longint'(bus.src_r_en & bus.dst_w_en), 0);
        chk("dense_enable_vs_busy", bus.dense_enable, bus.busy);
        if (bus.busy) chk("aybz_azby", bus.aybz_azby, exp_aybz);
        if (bus.src_r_en) begin
          if (q_rd.size() == 0) fail_evt("unexpected_read");
          else begin
            chk("src_r_addr", bus.src_r_addr, q_rd.pop_front());
            chk("x_r_addr", bus.x_r_addr, q_x.pop_front());
          end
          rd_cyc.push_back(cyc);
          last_rd = cyc;
        end
        if (bus.mac_enable != '0) begin
          if (q_mac.size() == 0) fail_evt("unexpected_mac");
          else chk("mac_enable", bus.mac_enable, mask_of(q_mac.pop_front()));
          if (rd_cyc.size() != 0) chk("mac_latency", cyc - rd_cyc.pop_front(), 1);
        end
        if (bus.dense_valid) begin
          if (dv_exp == 0) fail_evt("unexpected_dense_valid");
          else begin
            dv_exp--;
            chk("dense_valid_latency", cyc - last_rd, 1 + PIPE_LAT);
          end
        end
        if (bus.dst_w_en) begin
          if (q_wr.size() == 0) fail_evt("unexpected_write");
          else chk("dst_w_addr", bus.dst_w_addr, q_wr.pop_front());
        end
        if (bus.done) begin
          if (done_exp == 0) fail_evt("unexpected_done");
          else done_exp--;
          done_cnt++;
        end
      end
    end
  end

  task automatic flush();
    q_rd.delete(); q_x.delete(); q_mac.delete(); q_wr.delete(); rd_cyc.delete();
    dv_exp = 0;
    done_exp = 0;
  endtask

  task automatic drive(input bit p, input int k, input int m, input int wb, input int xb, input int yb);
    bus.ping        = p;
    bus.num_inputs  = 16'(k);
    bus.num_outputs = 16'(m);
    bus.w_base      = wb[ADDR_W-1:0];
    bus.x_base      = xb[ADDR_W-1:0];
    bus.y_base      = yb[ADDR_W-1:0];
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == prev) fail_evt("timeout_done");
    repeat (2) @(negedge clk);
    chk("leftover_reads", q_rd.size(), 0);
    chk("leftover_macs", q_mac.size(), 0);
    chk("leftover_writes", q_wr.size(), 0);
    chk("leftover_dense_valid", dv_exp, 0);
    chk("leftover_done", done_exp, 0);
    flush();
  endtask

  task automatic run_job(input bit p, input int k, input int m, input int wb, input int xb,
                         input int yb, input bit restart);
    int prev;
    prev = done_cnt;
    @(posedge clk); #2;
    push_model(k, m, wb, xb, yb);
    exp_aybz = {1'b1, p};
    drive(p, k, m, wb, xb, yb);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    if (restart) begin
      @(posedge clk); #2;
      drive(~p, k + 2, m + 7, wb + 100, xb + 5, yb + 50);
      bus.start = 1'b1;
      @(posedge clk); #2;
      bus.start = 1'b0;
    end
    wait_done(prev);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_src_r_en"}, bus.src_r_en, 0);
    chk({tag, "_src_r_addr"}, bus.src_r_addr, 0);
    chk({tag, "_dst_w_en"}, bus.dst_w_en, 0);
    chk({tag, "_dst_w_addr"}, bus.dst_w_addr, 0);
    chk({tag, "_mac_enable"}, bus.mac_enable, 0);
    chk({tag, "_dense_enable"}, bus.dense_enable, 0);
    chk({tag, "_dense_valid"}, bus.dense_valid, 0);
    chk({tag, "_aybz_azby"}, bus.aybz_azby, 2'b11);
  endtask

  initial begin
    int prev;
    int n;
    bus.start = 1'b0;
    drive(1'b1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    // Single full group, then a two-group layer with a partial second group.
    run_job(1'b1, 4, 32, 'h10, 'h0, 'h80, 1'b0);
    run_job(1'b0, 3, 40, 'h20, 'h100, 'h200, 1'b0);

    // Zero-length layers finish two cycles after start with no traffic.
    for (int z = 0; z < 2; z++) begin
      prev = done_cnt;
      @(posedge clk); #2;
      done_exp++;
      exp_aybz = 2'b11;
      drive(1'b1, (z == 0) ? 0 : 5, (z == 0) ? 9 : 0, 'h30, 'h40, 'h50);
      bus.start = 1'b1;
      @(posedge clk); #2;
      bus.start = 1'b0;
      @(negedge clk);
      chk("zero_busy", bus.busy, 1);
      chk("zero_done_early", bus.done, 0);
      @(negedge clk);
      chk("zero_done", bus.done, 1);
      wait_done(prev);
    end

    // Read address wraps past the top of the buffer.
    run_job(1'b1, 4, 5, AMOD - 2, AMOD - 1, AMOD - 3, 1'b0);

    // A second start during READ must not disturb the running layer.
    run_job(1'b0, 6, 10, 'h60, 'h70, 'h90, 1'b1);

    // Reset during WRITE of group 0.
    @(posedge clk); #2;
    push_model(3, 40, 'h11, 'h22, 'h33);
    exp_aybz = 2'b10;
    drive(1'b0, 3, 40, 'h11, 'h22, 'h33);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    n = 0;
    while (!bus.dst_w_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.dst_w_en) fail_evt("timeout_write");
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    mon_off = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_write_rst");
    flush();
    #1;
    mon_off = 1'b0;
    repeat (20) @(negedge clk);
    run_job(1'b1, 2, 33, 'h5, 'h6, 'h7, 1'b0);

    // Reset and start together: reset wins, nothing runs.
    @(posedge clk); #2;
    drive(1'b0, 2, 5, 'h1, 'h2, 'h3);
    bus.start = 1'b1;
    rst = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", bus.busy, 0);
    repeat (10) @(negedge clk);
    chk("rst_start_idle", bus.busy, 0);

    // Randomized layers against the model.
    for (int r = 0; r < 12; r++) begin
      int k, m;
      k = (r % 5 == 4) ? 0 : int'($urandom_range(1, 6));
      m = int'($urandom_range(1, 80));
      run_job(1'($urandom_range(0, 1)), k, m, int'($urandom_range(0, AMOD - 1)),
              int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dense_seq.md
DENSE_SEQ -- requirements
Module: dense_seq

Parameters
REQ-001 N_PE, default `N_PE (32): PE lanes, i.e. output neurons per group.
REQ-002 ADDR_W, default 10: buffer address width.
REQ-003 PIPE_LAT, default 3: cycles from last mac_enable to the PE-array accumulator being valid.

Interface
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; launches a layer when IDLE.
REQ-007 ping  in  1  1: BUF1 sources weights and input, BUF2 receives results; 0: roles swapped.
REQ-008 num_inputs  in  16  input vector length K.
REQ-009 num_outputs  in  16  output neuron count M.
REQ-010 w_base, x_base, y_base  in  ADDR_W each  weight, input (bank 32) and output base addresses.
REQ-011 aybz_azby  out  2  {1'b1, ping_q}; drives the dense routing mode.
REQ-012 src_r_en / src_r_addr  out  1 / ADDR_W  source-buffer read, common address to all banks.
REQ-013 dst_w_en / dst_w_addr  out  1 / ADDR_W  destination-buffer write.
REQ-014 mac_enable  out  N_PE  per-lane MAC enable.
REQ-015 dense_enable, dense_valid  out  1 each  PE-array dense mode; accumulator-capture pulse.
REQ-016 busy, done  out  1 each  layer active; one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, READ, DRAIN, WRITE, NEXT and FIN.
REQ-018 IDLE + start SHALL latch all inputs (ping_q, K, M, bases) and clear group g = 0; next state READ.
REQ-019 If K == 0 or M == 0 at start, IDLE SHALL go directly to FIN.
REQ-020 Inputs other than start are don't-care while busy.
REQ-021 Start while not IDLE SHALL be ignored.
REQ-022 READ, per cycle, for k = 0..K-1:
  - src_r_en = 1.
  - src_r_addr = w_base + g*K + k, truncated to ADDR_W.
  - Bank 32 supplies input word x_base + k through the mux.
REQ-023 Buffer read latency is 1 cycle.
  - mac_enable SHALL be asserted the cycle after each src_r_en, exactly K cycles per group.
  - Only lanes < min(N_PE, M - g*N_PE) are enabled; other lanes are 0.
REQ-024 After k = K-1, READ SHALL go to DRAIN.
  - DRAIN lasts 1 + PIPE_LAT cycles.
  - dense_valid pulses for exactly 1 cycle, in DRAIN's last cycle.
REQ-025 WRITE writes R = min(N_PE, M - g*N_PE) words, one per cycle, j = 0..R-1.
  - dst_w_en = 1, dst_w_addr = y_base + g*N_PE + j, truncated to ADDR_W.
REQ-026 NEXT (1 cycle):
  - g = g + 1.
  - If g*N_PE >= M, go to FIN; else go to READ with k = 0.
REQ-027 FIN SHALL pulse done for 1 cycle and return to IDLE.
REQ-028 busy = 1 in every state except IDLE.
REQ-029 dense_enable = busy.
REQ-030 src_r_en and dst_w_en SHALL never be high in the same cycle.
REQ-031 Address arithmetic SHALL be done at ≥ 32 bits and wrap modulo 2^ADDR_W.
REQ-032 All outputs SHALL be registered.
REQ-033 aybz_azby SHALL be constant while busy.

Reset
REQ-034 rst, sampled on a clk edge, SHALL force IDLE from any state, including mid-READ, mid-DRAIN and mid-WRITE.
REQ-035 Reset values:
  - Counters k, g, j = 0.
  - src_r_en = 0, src_r_addr = 0.
  - dst_w_en = 0, dst_w_addr = 0.
  - mac_enable = 0, dense_enable = 0, dense_valid = 0.
  - busy = 0, done = 0.
  - aybz_azby = 2'b11 (ping_q resets to 1).
REQ-036 rst and start in the same cycle: rst wins, start is discarded.

Verification
REQ-037 ping=1, K=4, M=32, w_base=0x10, x_base=0, y_base=0x80 -> expect:
  - src_r_addr 0x10..0x13 on 4 consecutive cycles.
  - mac_enable = all-ones for 4 cycles.
  - dense_valid 4 cycles after the last read.
  - 32 writes to 0x80..0x9F.
  - done; aybz_azby = 2'b11 throughout.
REQ-038 ping=0, K=3, M=40 -> expect:
  - Group 0: 32 lanes enabled, writes y_base+0..31.
  - Group 1: reads w_base+3..5, mac_enable = 0x000000FF, writes y_base+32..39.
  - aybz_azby = 2'b10.
REQ-039 K=0 or M=0 -> expect done 2 cycles after start; zero reads and zero writes.
REQ-040 Assert rst during WRITE of group 0 -> expect next cycle: all outputs at reset values, busy = 0, no further writes. A new start then runs normally.
REQ-041 Second start pulse mid-READ -> expect it ignored; the address sequence is unchanged.
REQ-042 w_base = 2^ADDR_W - 2, K=4 -> expect src_r_addr sequence: 2^ADDR_W-2, 2^ADDR_W-1, 0, 1.
